char_word_serializer: RTL and testbench

- Reverse path of the keyboard character packer, which assembles PS/2 keystrokes into a 32-bit word holding four 8-bit characters.
- This block takes such a packed word and replays it as a paced stream of single characters toward the text renderer / VGA character writer.
- Oldest character (most-significant byte) is emitted first; NUL bytes are optionally dropped.
- Single clock domain, valid/ready handshakes on both sides.

---
 rtl/char_word_serializer_pkg.sv | 15 +
 rtl/char_word_serializer_pace_counter.sv | 27 ++
 rtl/char_word_serializer.sv | 119 +++++++++++
 tb/tb_char_word_serializer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/char_word_serializer_pkg.sv
// Shared definitions for the keyboard character packer and its serializer counterpart.
// Both ends take byte order and state encodings from here.
package char_word_serializer_pkg;

    localparam int unsigned CHAR_W         = 8;
    localparam int unsigned CHARS_PER_WORD = 4;
    localparam int unsigned WORD_W         = CHAR_W * CHARS_PER_WORD;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EMIT = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [7:0] ASCII_NUL = 8'h00;

endpackage

// File: rtl/char_word_serializer_pace_counter.sv
// Loadable down-counter used to pace character output; expired is high at zero.
module pace_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/char_word_serializer.sv
// Replays a packed word as a paced stream of characters, oldest (MSB) byte first,
// optionally dropping NUL bytes.
module char_word_serializer #(
    parameter int unsigned CHAR_W         = char_word_serializer_pkg::CHAR_W,
    parameter int unsigned CHARS_PER_WORD = char_word_serializer_pkg::CHARS_PER_WORD,
    parameter int unsigned SKIP_NULL      = 1,
    parameter int unsigned CHAR_GAP       = 2,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [CHAR_W*CHARS_PER_WORD-1:0] word_in,
    input  logic                             word_valid,
    output logic                             word_ready,
    output logic [CHAR_W-1:0]                char_out,
    output logic                             char_valid,
    input  logic                             char_ready,
    output logic                             word_done,
    output logic                             busy,
    output logic [CNT_W-1:0]                 char_count
);

    import char_word_serializer_pkg::*;

    localparam int unsigned WW    = CHAR_W * CHARS_PER_WORD;
    localparam int unsigned IDX_W = (CHARS_PER_WORD > 1) ? $clog2(CHARS_PER_WORD) : 1;
    localparam int unsigned GAP_W = (CHAR_GAP > 0) ? $clog2(CHAR_GAP + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHARS_PER_WORD - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((CHAR_GAP > 0) ? CHAR_GAP - 1 : 0);

    logic [1:0]        state;
    logic [WW-1:0]     shift_reg;
    logic [IDX_W-1:0]  idx;
    logic [CHAR_W-1:0] char_hold;
    logic [CHAR_W-1:0] cur_byte;
    logic              in_emit;
    logic              is_skip;
    logic              last;
    logic              advance;
    logic              fire;
    logic              gap_load;
    logic              gap_expired;

    always_comb begin
        cur_byte   = shift_reg[WW-1 -: CHAR_W];
        in_emit    = (state == ST_EMIT);
        is_skip    = (SKIP_NULL != 0) && (cur_byte == CHAR_W'(ASCII_NUL));
        last       = (idx == LAST_IDX);
        char_valid = in_emit && !is_skip;
        fire       = char_valid && char_ready;
        // Skipped bytes advance unconditionally; real ones wait for the handshake.
        advance    = in_emit && (is_skip || char_ready);
        gap_load   = fire && !last && (CHAR_GAP > 0);
        // char_hold keeps the last emitted byte visible outside EMIT.
        char_out   = in_emit ? cur_byte : char_hold;
        word_ready = (state == ST_IDLE) && !reset;
        busy       = (state != ST_IDLE);
    end

    pace_counter #(
        .W (GAP_W)
    ) u_pace (
        .clock      (clock),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GAP_LOAD),
        .enable     (state == ST_GAP),
        .expired    (gap_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            idx        <= '0;
            char_hold  <= '0;
            char_count <= '0;
            word_done  <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (in_emit) begin
                char_hold <= cur_byte;
            end
            if (fire && (char_count != '1)) begin
                char_count <= char_count + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (word_valid) begin
                        shift_reg <= word_in;
                        idx       <= '0;
                        state     <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (advance) begin
                        if (last) begin
                            word_done <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            shift_reg <= shift_reg << CHAR_W;
                            idx       <= idx + 1'b1;
                            if (!is_skip && (CHAR_GAP > 0)) begin
                                state <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_expired) begin
                        state <= ST_EMIT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_word_serializer.sv
// Directed bench for char_word_serializer: one NUL-skipping instance and one
// NUL-keeping instance with a narrow saturating counter.
module tb_char_word_serializer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] word_in = '0;
    logic        wv1 = 1'b0;
    logic        wv0 = 1'b0;
    logic        char_ready = 1'b1;
    logic        sel = 1'b1;

    logic        ready1, valid1, done1, busy1;
    logic [7:0]  char1;
    logic [15:0] cnt1;
    logic        ready0, valid0, done0, busy0;
    logic [7:0]  char0;
    logic [1:0]  cnt0;

    logic        o_ready, o_valid, o_done, o_busy;
    logic [7:0]  o_char;
    logic [15:0] o_cnt;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    int unsigned vo[$], dn[$], rq[$], aq[$];
    logic [7:0]  vc[$];
    int unsigned exp_vo[$];
    logic [7:0]  exp_vc[$];

    always #5 clock = ~clock;

    char_word_serializer #(
        .SKIP_NULL (1),
        .CHAR_GAP  (2),
        .CNT_W     (16)
    ) dut1 (
        .clock      (clock),
        .reset      (reset),
        .word_in    (word_in),
        .word_valid (wv1),
        .word_ready (ready1),
        .char_out   (char1),
        .char_valid (valid1),
        .char_ready (char_ready),
        .word_done  (done1),
        .busy       (busy1),
        .char_count (cnt1)
    );

    char_word_serializer #(
        .SKIP_NULL (0),
        .CHAR_GAP  (2),
        .CNT_W     (2)
    ) dut0 (
        .clock      (clock),
        .reset      (reset),
        .word_in    (word_in),
        .word_valid (wv0),
        .word_ready (ready0),
        .char_out   (char0),
        .char_valid (valid0),
        .char_ready (char_ready),
        .word_done  (done0),
        .busy       (busy0),
        .char_count (cnt0)
    );

    always_comb begin
        o_ready = sel ? ready1 : ready0;
        o_valid = sel ? valid1 : valid0;
        o_done  = sel ? done1  : done0;
        o_busy  = sel ? busy1  : busy0;
        o_char  = sel ? char1  : char0;
        o_cnt   = sel ? cnt1   : {14'd0, cnt0};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at edge+1 of a cycle in which the DUT is idle; returns at edge+1 of cycle N+1.
    task automatic accept(input logic [31:0] w, input bit hold);
        word_in = w;
        if (sel) wv1 = 1'b1; else wv0 = 1'b1;
        #1;
        check("accept_ready", {31'd0, o_ready}, 32'd1);
        @(posedge clock); #1;
        if (!hold) begin
            wv1 = 1'b0;
            wv0 = 1'b0;
        end
    endtask

    task automatic watch(input int unsigned ncyc, input int unsigned stall_from,
                         input int unsigned stall_len, input logic [7:0] stall_char,
                         input logic [15:0] stall_cnt);
        bit acc;
        vo.delete(); vc.delete(); dn.delete(); rq.delete(); aq.delete();
        for (int unsigned off = 1; off <= ncyc; off++) begin
            char_ready = !((off >= stall_from) && (off < stall_from + stall_len));
            #1;
            if (o_valid && char_ready) begin
                vo.push_back(off);
                vc.push_back(o_char);
            end
            if (o_done)  dn.push_back(off);
            if (o_ready) rq.push_back(off);
            acc = (sel ? wv1 : wv0) && o_ready;
            if (acc) aq.push_back(off);
            if (!char_ready) begin
                check("stall_valid", {31'd0, o_valid}, 32'd1);
                check("stall_char", {24'd0, o_char}, {24'd0, stall_char});
                check("stall_cnt", {16'd0, o_cnt}, {16'd0, stall_cnt});
            end
            @(posedge clock); #1;
            if (acc) begin
                wv1 = 1'b0;
                wv0 = 1'b0;
            end
        end
        char_ready = 1'b1;
    endtask

    task automatic compare_stream(input string tag, input int unsigned exp_done);
        check({tag, "_nchars"}, vo.size(), exp_vo.size());
        for (int i = 0; i < vo.size() && i < exp_vo.size(); i++) begin
            check({tag, "_off"}, vo[i], exp_vo[i]);
            check({tag, "_char"}, {24'd0, vc[i]}, {24'd0, exp_vc[i]});
        end
        check({tag, "_ndone"}, dn.size(), 32'd1);
        if (dn.size() > 0) check({tag, "_done_off"}, dn[0], exp_done);
    endtask

    initial begin
        #2 reset = 1'b1;
        #1;
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_char", {24'd0, o_char}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_cnt", {16'd0, o_cnt}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Basic word, gap 2
        accept(32'h41424344, 1'b0);
        watch(14, 0, 0, 8'h00, 16'd0);
        exp_vo = '{1, 4, 7, 10};
        exp_vc = '{8'h41, 8'h42, 8'h43, 8'h44};
        compare_stream("basic", 11);
        check("basic_cnt", {16'd0, o_cnt}, 32'd4);

        // NUL bytes skipped
        accept(32'h00410042, 1'b0);
        watch(9, 0, 0, 8'h00, 16'd0);
        exp_vo = '{2, 6};
        exp_vc = '{8'h41, 8'h42};
        compare_stream("skip", 7);
        check("skip_cnt", {16'd0, o_cnt}, 32'd6);

        // NUL bytes kept; 2-bit counter saturates at 3
        sel = 1'b0;
        accept(32'h00410042, 1'b0);
        watch(13, 0, 0, 8'h00, 16'd0);
        exp_vo = '{1, 4, 7, 10};
        exp_vc = '{8'h00, 8'h41, 8'h00, 8'h42};
        compare_stream("keep", 11);
        check("keep_cnt_sat", {16'd0, o_cnt}, 32'd3);
        sel = 1'b1;

        // All-zero word
        accept(32'h00000000, 1'b0);
        watch(7, 0, 0, 8'h00, 16'd0);
        exp_vo.delete();
        exp_vc.delete();
        compare_stream("zero", 5);
        check("zero_ready_off", rq.size() > 0 ? rq[0] : 0, 32'd5);
        check("zero_cnt", {16'd0, o_cnt}, 32'd6);

        // Backpressure on the first character
        accept(32'h21222324, 1'b0);
        watch(18, 1, 5, 8'h21, 16'd6);
        exp_vo = '{6, 9, 12, 15};
        exp_vc = '{8'h21, 8'h22, 8'h23, 8'h24};
        compare_stream("stall", 16);
        check("stall_cnt_end", {16'd0, o_cnt}, 32'd10);

        // Second word held valid while busy; accepted only once back in IDLE
        accept(32'h31323334, 1'b1);
        word_in = 32'h61626364;
        watch(26, 0, 0, 8'h00, 16'd0);
        exp_vo = '{1, 4, 7, 10, 12, 15, 18, 21};
        exp_vc = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h61, 8'h62, 8'h63, 8'h64};
        check("busy_ndone", dn.size(), 32'd2);
        check("busy_nacc", aq.size(), 32'd1);
        if (aq.size() > 0) check("busy_acc_off", aq[0], 32'd11);
        check("busy_nchars", vo.size(), exp_vo.size());
        for (int i = 0; i < vo.size() && i < exp_vo.size(); i++) begin
            check("busy_off", vo[i], exp_vo[i]);
            check("busy_char", {24'd0, vc[i]}, {24'd0, exp_vc[i]});
        end
        check("busy_cnt", {16'd0, o_cnt}, 32'd18);

        // Asynchronous reset in the gap after the second character
        accept(32'h41424344, 1'b0);
        watch(4, 0, 0, 8'h00, 16'd0);
        #1;
        check("gap_hold_char", {24'd0, o_char}, 32'h42);
        check("gap_valid", {31'd0, o_valid}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready", {31'd0, o_ready}, 32'd0);
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_char", {24'd0, o_char}, 32'd0);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_cnt", {16'd0, o_cnt}, 32'd0);
        repeat (2) begin
            @(posedge clock); #1;
            check("mid_rst_done", {31'd0, o_done}, 32'd0);
        end
        reset = 1'b0;
        accept(32'h45000000, 1'b0);
        watch(9, 0, 0, 8'h00, 16'd0);
        exp_vo = '{1};
        exp_vc = '{8'h45};
        compare_stream("post_rst", 7);
        check("post_rst_cnt", {16'd0, o_cnt}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
